// File: rtl/pe_8ip_seq_ctrl_pkg.sv
// Shared types and constants for the PE_8IP sequencer: state encoding,
// mux select / addsub op codes and the packed select patterns per phase.
package pe_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_L1    = 3'd1,
        ST_AGGR  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    localparam logic [1:0] SEL_XY   = 2'd0;
    localparam logic [1:0] SEL_MULT = 2'd1;
    localparam logic [1:0] SEL_AGGR = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;

    // Packed as {m9, m8, m7 .. m0}
    localparam logic [19:0] STOP_SEL = {SEL_AGGR, SEL_AGGR, {8{SEL_ZERO}}};
    localparam logic [19:0] L1_SEL   = {SEL_XY, SEL_XY, {4{SEL_XY}}, {4{SEL_MULT}}};
    localparam logic [19:0] AGGR_SEL = {SEL_XY, SEL_XY, {4{SEL_AGGR}}, {4{SEL_MULT}}};

    localparam logic [3:0] L1_OPS   = {OP_SUB, OP_SUB};
    localparam logic [3:0] AGGR_OPS = {OP_ADD, OP_ADD};

endpackage

// File: rtl/pe_8ip_seq_ctrl_phase_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module pe_seq_phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pe_8ip_seq_ctrl.sv
// Sequencer for one PE_8IP processing element: L1 -> AGGR -> DRAIN -> capture.
// Define PE_SEQ_CHECK_EN to add the io_expected / io_pass result compare.
module pe_8ip_seq_ctrl
    import pe_seq_pkg::*;
#(
    parameter int L1_CYCLES    = 30,
    parameter int AGGR_CYCLES  = 76,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_start,
    input  logic        io_abort,
    input  logic        io_mode_int,
    input  logic [2:0]  io_rounding,
    input  logic [31:0] io_pe_out,
    output logic [19:0] io_m_sel,
    output logic [3:0]  io_addsub_op,
    output logic        io_use_int,
    output logic        io_tininess,
    output logic [2:0]  io_rounding_o,
    output logic        io_busy,
    output logic        io_done,
    output logic [31:0] io_result
`ifdef PE_SEQ_CHECK_EN
    ,
    input  logic [31:0] io_expected,
    output logic        io_pass
`endif
);

    localparam logic [CNT_W-1:0] L1_LOAD    = CNT_W'(L1_CYCLES - 1);
    localparam logic [CNT_W-1:0] AGGR_LOAD  = CNT_W'(AGGR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_zero;
    logic             w_capture;
    logic             w_accept;
    logic             r_mode_int;
    logic [2:0]       r_rounding;
    logic [31:0]      r_result;

    pe_seq_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort is checked before counter expiry so it wins in the same cycle.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_capture  = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_start) begin
                    w_accept   = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = L1_LOAD;
                    w_next     = ST_L1;
                end
            end
            ST_L1: begin
                if (io_abort) begin
                    w_next = ST_IDLE;
                end else if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = AGGR_LOAD;
                    w_next     = ST_AGGR;
                end
            end
            ST_AGGR: begin
                if (io_abort) begin
                    w_next = ST_IDLE;
                end else if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = DRAIN_LOAD;
                    w_next     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (io_abort) begin
                    w_next = ST_IDLE;
                end else if (w_zero) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_dec = (r_state == ST_L1) || (r_state == ST_AGGR) || (r_state == ST_DRAIN);

    // DRAIN keeps the add ops left over from AGGR, which are the idle value too.
    always_comb begin
        io_m_sel     = STOP_SEL;
        io_addsub_op = AGGR_OPS;
        case (r_state)
            ST_L1: begin
                io_m_sel     = L1_SEL;
                io_addsub_op = L1_OPS;
            end
            ST_AGGR: begin
                io_m_sel     = AGGR_SEL;
                io_addsub_op = AGGR_OPS;
            end
            default: begin
                io_m_sel     = STOP_SEL;
                io_addsub_op = AGGR_OPS;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mode_int <= 1'b0;
            r_rounding <= 3'd0;
        end else if (w_accept) begin
            r_mode_int <= io_mode_int;
            r_rounding <= io_rounding;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
        end else if (w_capture) begin
            r_result <= io_pe_out;
        end
    end

`ifdef PE_SEQ_CHECK_EN
    logic r_pass;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pass <= 1'b0;
        end else if (w_capture) begin
            r_pass <= (io_pe_out == io_expected);
        end
    end

    assign io_pass = r_pass;
`endif

    assign io_use_int    = r_mode_int;
    assign io_rounding_o = r_rounding;
    assign io_tininess   = 1'b1;
    assign io_busy       = w_dec;
    assign io_done       = (r_state == ST_DONE);
    assign io_result     = r_result;

endmodule

// File: tb/tb_pe_8ip_seq_ctrl.sv
// Scoreboard bench for pe_8ip_seq_ctrl: jobs push expected results, a monitor
// pops them on every io_done and compares result and done cycle.
module tb_pe_8ip_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_start = 1'b0;
  logic        io_abort = 1'b0;
  logic        io_mode_int = 1'b0;
  logic [2:0]  io_rounding = 3'd0;
  logic [31:0] io_pe_out = 32'd0;
  logic [19:0] io_m_sel;
  logic [3:0]  io_addsub_op;
  logic        io_use_int;
  logic        io_tininess;
  logic [2:0]  io_rounding_o;
  logic        io_busy;
  logic        io_done;
  logic [31:0] io_result;
`ifdef PE_SEQ_CHECK_EN
  logic [31:0] io_expected = 32'd0;
  logic        io_pass;
`endif

  pe_8ip_seq_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .io_start      (io_start),
    .io_abort      (io_abort),
    .io_mode_int   (io_mode_int),
    .io_rounding   (io_rounding),
    .io_pe_out     (io_pe_out),
    .io_m_sel      (io_m_sel),
    .io_addsub_op  (io_addsub_op),
    .io_use_int    (io_use_int),
    .io_tininess   (io_tininess),
    .io_rounding_o (io_rounding_o),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_result     (io_result)
`ifdef PE_SEQ_CHECK_EN
    ,
    .io_expected   (io_expected),
    .io_pass       (io_pass)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard
  typedef struct {
    logic [31:0] res;
    int          done_cyc;
    logic        pass;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_result = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (reset && io_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got io_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", io_result, mon_e.res);
        check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
        check("busy_in_done", {31'd0, io_busy}, 32'd0);
`ifdef PE_SEQ_CHECK_EN
        check("pass", {31'd0, io_pass}, {31'd0, mon_e.pass});
`endif
      end
    end
  end

  // driver: called at the negedge of cycle 0 (DUT in IDLE); returns at the
  // negedge of cycle 109 (DONE), or in IDLE a few cycles after an abort.
  // abort_k = -1 asserts abort in the IDLE cycle together with start.
  task automatic run_job(input logic mode, input logic [2:0] rnd, input logic [31:0] val,
                         input logic [31:0] expv, input int abort_k, input int pulse_k,
                         input bit hold);
    exp_t e;
    io_start    = 1'b1;
    io_mode_int = mode;
    io_rounding = rnd;
    io_pe_out   = ~val;
    io_abort    = (abort_k == -1);
`ifdef PE_SEQ_CHECK_EN
    io_expected = expv;
`endif
    if (abort_k <= 0) begin
      e.res      = val;
      e.done_cyc = cyc + 109;
      e.pass     = (val == expv);
      exp_q.push_back(e);
    end
    for (int k = 1; k <= 109; k++) begin
      @(negedge clock);
      if (k == 1) begin
        if (!hold) io_start = 1'b0;
        if (abort_k == -1) io_abort = 1'b0;
        io_mode_int = ~mode;
        io_rounding = ~rnd;
        check("busy_l1", {31'd0, io_busy}, 32'd1);
        check("msel_l1", {12'd0, io_m_sel}, 32'h0005_5);
        check("op_l1", {28'd0, io_addsub_op}, 32'h5);
      end
      if (k == 31) begin
        check("msel_aggr", {12'd0, io_m_sel}, 32'h0000_AA55);
        check("op_aggr", {28'd0, io_addsub_op}, 32'h0);
      end
      if (k == 60) begin
        check("use_int", {31'd0, io_use_int}, {31'd0, mode});
        check("rounding_o", {29'd0, io_rounding_o}, {29'd0, rnd});
        check("tininess", {31'd0, io_tininess}, 32'd1);
      end
      if (k == 107) begin
        check("msel_drain", {12'd0, io_m_sel}, 32'h000A_FFFF);
        check("op_drain", {28'd0, io_addsub_op}, 32'h0);
        check("busy_drain", {31'd0, io_busy}, 32'd1);
      end
      if (pulse_k != 0 && k == pulse_k) io_start = 1'b1;
      if (pulse_k != 0 && k == pulse_k + 1) io_start = 1'b0;
      if (abort_k > 0 && k == abort_k) io_abort = 1'b1;
      if (abort_k > 0 && k == abort_k + 1) begin
        io_abort = 1'b0;
        check("busy_abort", {31'd0, io_busy}, 32'd0);
        check("msel_abort", {12'd0, io_m_sel}, 32'h000A_FFFF);
        check("done_abort", {31'd0, io_done}, 32'd0);
        repeat (5) @(negedge clock);
        check("result_after_abort", io_result, last_result);
        return;
      end
      io_pe_out = (k == 108) ? val : ~val;
    end
    check("use_int_done", {31'd0, io_use_int}, {31'd0, mode});
    last_result = val;
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clock);
    check("rst_msel", {12'd0, io_m_sel}, 32'h000A_FFFF);
    check("rst_op", {28'd0, io_addsub_op}, 32'h0);
    check("rst_busy", {31'd0, io_busy}, 32'd0);
    check("rst_done", {31'd0, io_done}, 32'd0);
    check("rst_result", io_result, 32'd0);
    check("rst_tininess", {31'd0, io_tininess}, 32'd1);
    check("rst_use_int", {31'd0, io_use_int}, 32'd0);
    check("rst_rounding", {29'd0, io_rounding_o}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // reset asserted mid-L1
    io_start = 1'b1;
    io_mode_int = 1'b1;
    io_rounding = 3'd5;
    @(negedge clock);
    io_start = 1'b0;
    repeat (9) @(negedge clock);
    check("midl1_busy", {31'd0, io_busy}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_msel", {12'd0, io_m_sel}, 32'h000A_FFFF);
    check("midrst_busy", {31'd0, io_busy}, 32'd0);
    check("midrst_done", {31'd0, io_done}, 32'd0);
    check("midrst_use_int", {31'd0, io_use_int}, 32'd0);
    check("midrst_rounding", {29'd0, io_rounding_o}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // INT job, result -256; matching expected value
    run_job(1'b1, 3'b000, 32'hFFFF_FF00, 32'hFFFF_FF00, 0, 0, 1'b0);
    @(negedge clock);
    // FP job, rounding 100, abort raised in IDLE alongside start; mismatching expected
    run_job(1'b0, 3'b100, 32'hC380_0000, 32'h0000_0000, -1, 0, 1'b0);
    @(negedge clock);
    // abort at AGGR cycle 10
    run_job(1'b1, 3'b010, 32'h1234_5678, 32'h0, 40, 0, 1'b0);
    @(negedge clock);
    // start pulse in AGGR is ignored
    run_job(1'b1, 3'b001, 32'hA5A5_0001, 32'h0, 0, 50, 1'b0);
    @(negedge clock);
    // start held high: second job accepted the cycle after DONE
    run_job(1'b1, 3'b011, 32'h0000_1111, 32'h0, 0, 0, 1'b1);
    @(negedge clock);
    run_job(1'b0, 3'b110, 32'h2222_0000, 32'h2222_0000, 0, 0, 1'b0);
    repeat (5) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("idle_busy", {31'd0, io_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
